lc3_mem_resp: RTL and testbench

- Memory responder for the LC3 core; the target side of the fetch/load/store request bus.
- Samples a 16-bit word address and a read or write strobe from the requester.
- Inserts a fixed programmable wait latency, then performs the access on an internal word array.
- Returns read data with a one-cycle rdy pulse; flags out-of-window or malformed requests with err.

---
 rtl/lc3_mem_resp.sv | 120 ++++++++++++
 tb/tb_lc3_mem_resp.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/lc3_mem_resp.sv
// lc3_mem_resp: memory responder on the LC3 fetch/load/store request bus.
// A request is sampled in IDLE, held for LAT wait cycles, then the access is
// performed on an internal 2^AW x 16 word array.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   addr[15:0] word address from requester
//   rd, wr     read / write strobes (only a definite 1 counts)
//   din[15:0]  write data
//   dout[15:0] read data, valid with rdy on a read, held afterwards
//   rdy        one-cycle completion pulse
//   err        out-of-window or rd+wr request, valid with rdy
//   busy       request in flight (WAIT or RESP)
module lc3_mem_resp #(
    parameter int          AW   = 10,
    parameter logic [15:0] BASE = 16'h3000,
    parameter int          LAT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        rdy,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0]  LAT_M1 = 4'(LAT - 1);
    localparam logic [16:0] WORDS  = 17'(1 << AW);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [15:0] addr_q, din_q;
    logic        rd_q, wr_q;
    logic [15:0] mem [0:(1 << AW) - 1];

    logic        rd_s, wr_s, req;
    logic [15:0] off;
    logic        in_win, access, bad_op, do_wr;
    logic [AW-1:0] idx;

    // Case equality so an x/z strobe reads as idle rather than propagating.
    assign rd_s = (rd === 1'b1);
    assign wr_s = (wr === 1'b1);
    assign req  = rd_s | wr_s;

    // Explicit lower-bound check keeps addresses below BASE from wrapping
    // around into the top of the window.
    assign off    = addr_q - BASE;
    assign in_win = (addr_q >= BASE) && ({1'b0, off} < WORDS);
    assign idx    = off[AW-1:0];

    assign access = (state == WAIT) && (cnt == 4'd0);
    assign bad_op = rd_q & wr_q;
    assign do_wr  = access & wr_q & ~rd_q & in_win;

    assign busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (req) begin
                state_nx = WAIT;
                cnt_nx   = LAT_M1;
            end
            WAIT: begin
                if (cnt == 4'd0) state_nx = RESP;
                else             cnt_nx   = cnt - 4'd1;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Request capture; only meaningful once the request reaches WAIT.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            addr_q <= addr;
            din_q  <= din;
            rd_q   <= rd_s;
            wr_q   <= wr_s;
        end
    end

    // Array contents survive reset; a reset in WAIT forces IDLE so do_wr
    // never fires for the aborted request.
    always_ff @(posedge clk) begin
        if (do_wr) mem[idx] <= din_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= 16'h0000;
            rdy  <= 1'b0;
            err  <= 1'b0;
        end else begin
            rdy <= access;
            err <= access & (bad_op | ~in_win);
            if (access && !bad_op && rd_q)
                dout <= in_win ? mem[idx] : 16'h0000;
        end
    end

endmodule

// File: tb/tb_lc3_mem_resp.sv
module tb_lc3_mem_resp;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // LAT=2 instance (main vectors)
    logic [15:0] addr = 16'h0, din = 16'h0, dout;
    logic        rd = 1'b0, wr = 1'b0, rdy, err, busy;
    // LAT=1 instance (back-to-back sequence)
    logic [15:0] b_addr = 16'h0, b_din = 16'h0, b_dout;
    logic        b_rd = 1'b0, b_wr = 1'b0, b_rdy, b_err, b_busy;

    lc3_mem_resp #(.AW(10), .BASE(16'h3000), .LAT(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .din(din),
        .dout(dout), .rdy(rdy), .err(err), .busy(busy));

    lc3_mem_resp #(.AW(10), .BASE(16'h3000), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .addr(b_addr), .rd(b_rd), .wr(b_wr), .din(b_din),
        .dout(b_dout), .rdy(b_rdy), .err(b_err), .busy(b_busy));

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] dout;   // dout expected during rdy
        logic        err;
    } vec_t;

    vec_t vt [16];

    // One request on the LAT=2 instance; called at a negedge with the DUT idle.
    task automatic do_req(input string tag, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_dout, input logic exp_err);
        int lat;
        rd = r; wr = w; addr = a; din = d;
        @(negedge clk);                       // accept edge has passed
        rd = 1'b0; wr = 1'b0; addr = 16'h2ABC; din = 16'hFFFF;
        check({tag, "_busy0"}, 16'(busy), 16'd1);
        check({tag, "_rdy0"},  16'(rdy),  16'd0);
        lat = 0;
        while (rdy !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"},  16'(lat),  16'd2);
        check({tag, "_err"},  16'(err),  16'(exp_err));
        check({tag, "_dout"}, dout,      exp_dout);
        check({tag, "_busyr"}, 16'(busy), 16'd1);
        @(negedge clk);
        check({tag, "_rdyclr"}, 16'(rdy),  16'd0);
        check({tag, "_errclr"}, 16'(err),  16'd0);
        check({tag, "_idle"},   16'(busy), 16'd0);
    endtask

    initial begin
        int nrdy;
        vt[0]  = '{1'b0, 1'b1, 16'h3000, 16'h1234, 16'h0000, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 16'h3005, 16'hBEEF, 16'h1234, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 16'h3005, 16'h0000, 16'hBEEF, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 16'h2FFF, 16'h0000, 16'h0000, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 16'h33FF, 16'h5A5A, 16'h0000, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 16'h33FF, 16'h0000, 16'h5A5A, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 16'h3400, 16'h0000, 16'h0000, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 16'h3001, 16'h1111, 16'h0000, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 16'h3001, 16'h2222, 16'h0000, 1'b1};
        vt[10] = '{1'b1, 1'b0, 16'h3001, 16'h0000, 16'h1111, 1'b0};
        vt[11] = '{1'b0, 1'b1, 16'h2FFF, 16'h7777, 16'h1111, 1'b1};
        vt[12] = '{1'b1, 1'b0, 16'h33FF, 16'h0000, 16'h5A5A, 1'b0};
        vt[13] = '{1'b0, 1'b1, 16'h3400, 16'h9999, 16'h5A5A, 1'b1};
        vt[14] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0};
        vt[15] = '{1'b0, 1'b1, 16'h3010, 16'h0ABC, 16'h1234, 1'b0};

        // reset state
        #1;
        check("rst_dout", dout, 16'h0000);
        check("rst_rdy",  16'(rdy),  16'd0);
        check("rst_err",  16'(err),  16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_busy1", 16'(b_busy), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            do_req($sformatf("v%0d", i), vt[i].rd, vt[i].wr, vt[i].addr,
                   vt[i].din, vt[i].dout, vt[i].err);

        // reset in the middle of WAIT aborts a write
        wr = 1'b1; addr = 16'h3010; din = 16'hDEAD;
        @(negedge clk);
        wr = 1'b0;
        check("abort_busy", 16'(busy), 16'd1);
        rst = 1'b0;
        #1;
        check("abort_busy0", 16'(busy), 16'd0);
        check("abort_rdy",   16'(rdy),  16'd0);
        check("abort_err",   16'(err),  16'd0);
        check("abort_dout",  dout,      16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        nrdy = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (rdy === 1'b1) nrdy++;
        end
        check("abort_no_rdy", 16'(nrdy), 16'd0);
        do_req("abort_rd", 1'b1, 1'b0, 16'h3010, 16'h0000, 16'h0ABC, 1'b0);

        // LAT=1, rd held high: write 3020 first, then reads every 3 cycles
        b_wr = 1'b1; b_addr = 16'h3020; b_din = 16'h4242;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (t == 0) begin
                b_wr = 1'b0;
                b_rd = 1'b1;
            end
            check($sformatf("b2b_rdy_t%0d", t), 16'(b_rdy), 16'((t % 3) == 1));
            if ((t % 3) == 1) begin
                check($sformatf("b2b_err_t%0d", t), 16'(b_err), 16'd0);
                check($sformatf("b2b_dout_t%0d", t), b_dout,
                      (t == 1) ? 16'h0000 : 16'h4242);
            end
            // correct address only at the cycle before each accept edge
            if (((t + 1) % 3) == 0) begin
                b_addr = 16'h3020;
                b_din  = 16'h0000;
            end else begin
                b_addr = 16'h2000;
                b_din  = 16'(t * 16'h1111);
            end
        end
        b_rd = 1'b0;
        for (int t = 0; t < 4; t++) @(negedge clk);
        check("b2b_idle", 16'(b_busy), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
